// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 8N1 UART transmitter among NUM_REQ byte sources.
// Round-robin by default; define UART_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned FRAME_CYCLES = DATA_WIDTH + 2
) (
    input  logic                          tx_clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_enable,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          tx_done
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(FRAME_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWait
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_enable_q, tx_enable_d;
    logic                  busy_q, busy_d;
    logic [IdW-1:0]        grant_id_q, grant_id_d;
    logic [IdW-1:0]        last_q, last_d;
    logic [CntW-1:0]       cnt_q, cnt_d;

    logic                  win_vld;
    logic [IdW-1:0]        win_id;
    logic                  accept;

`ifdef UART_ARB_FIXED_PRIO_EN
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_vld = 1'b1;
                win_id  = IdW'(i);
            end
        end
    end
`else
    // Rotate so bit 0 is the requester just after last_q; the lowest set bit then wins.
    logic [2*NUM_REQ-1:0] dbl_req;
    logic [NUM_REQ-1:0]   rot_req;
    int                   win_sum;

    always_comb begin
        dbl_req = {req_valid, req_valid};
        rot_req = NUM_REQ'(dbl_req >> (int'(last_q) + 1));
        win_vld = 1'b0;
        win_sum = 0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                win_vld = 1'b1;
                win_sum = int'(last_q) + 1 + i;
            end
        end
        win_id = IdW'(win_sum % int'(NUM_REQ));
    end
`endif

    assign accept = (state_q == StIdle) && win_vld;

    // Gated by rst_n so no accept pulse leaks out while reset is held.
    always_comb begin
        req_ready = '0;
        if (accept && rst_n) begin
            req_ready[win_id] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_enable_d = 1'b0;
        busy_d      = busy_q;
        grant_id_d  = grant_id_q;
        last_d      = last_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    tx_data_d   = req_data[win_id*DATA_WIDTH +: DATA_WIDTH];
                    grant_id_d  = win_id;
                    tx_enable_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = StLaunch;
`ifndef UART_ARB_FIXED_PRIO_EN
                    last_d      = win_id;
`endif
                end
            end
            StLaunch: begin
                cnt_d   = CntW'(FRAME_CYCLES - 1);
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            tx_data_q   <= '0;
            tx_enable_q <= 1'b0;
            busy_q      <= 1'b0;
            grant_id_q  <= '0;
            last_q      <= IdW'(NUM_REQ - 1);
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            tx_enable_q <= tx_enable_d;
            busy_q      <= busy_d;
            grant_id_q  <= grant_id_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_enable = tx_enable_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;
    assign tx_done   = (state_q == StWait) && (cnt_q == '0);

    // The transmitter samples data_in live, so the byte must not move mid-frame.
    a_enable_single : assert property (@(posedge tx_clk) disable iff (!rst_n)
        tx_enable |=> !tx_enable);
    a_enable_launch : assert property (@(posedge tx_clk) disable iff (!rst_n)
        tx_enable |-> (state_q == StLaunch));
    a_data_stable   : assert property (@(posedge tx_clk) disable iff (!rst_n)
        (state_q == StWait) |-> $stable(tx_data));
    a_ready_onehot  : assert property (@(posedge tx_clk) disable iff (!rst_n)
        $onehot0(req_ready));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a small serial transmitter model on tx_data/tx_enable.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    logic             tx_clk    = 1'b0;
    logic             rst_n     = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*DW-1:0] req_data  = '0;
    logic [NR-1:0]    req_ready;
    logic [DW-1:0]    tx_data;
    logic             tx_enable;
    logic             busy;
    logic [1:0]       grant_id;
    logic             tx_done;

    uart_tx_arbiter #(
        .NUM_REQ   (NR),
        .DATA_WIDTH(DW)
    ) dut (
        .tx_clk   (tx_clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .tx_data  (tx_data),
        .tx_enable(tx_enable),
        .busy     (busy),
        .grant_id (grant_id),
        .tx_done  (tx_done)
    );

    always #5 tx_clk = ~tx_clk;

    typedef struct {
        int         id;
        logic [7:0] data;
        int         gap;  // required cycles since previous accept, 0 = don't care
    } acc_t;

    acc_t       exp_q[$];
    logic [7:0] ser_q[$];
    int         plan[$];
    logic [7:0] byt[NR];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int prev_acc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Transmitter model: 0 idle, 1 START, 2..9 data bits (LSB first), 10 FINISH.
    int   txm_pos = 0;
    logic txm_line;

    always @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) txm_pos <= 0;
        else if (txm_pos == 0) txm_pos <= tx_enable ? 1 : 0;
        else if (txm_pos == 10) txm_pos <= 0;
        else txm_pos <= txm_pos + 1;
    end

    assign txm_line = (txm_pos == 1) ? 1'b0 :
                      (txm_pos >= 2 && txm_pos <= 9) ? tx_data[3'(txm_pos - 2)] : 1'b1;

    // Monitor: pops the scoreboard on each accept and follows the frame it started.
    bit         fr_act = 1'b0;
    int         fr_age = 0;
    int         fr_id = 0;
    logic [7:0] fr_data = '0;
    bit         prev_en = 1'b0;
    logic [7:0] cap = '0;
    acc_t       e;

    always @(negedge tx_clk) begin
        cyc++;
        if (!rst_n) begin
            fr_act   = 1'b0;
            prev_acc = -1;
            prev_en  = 1'b0;
            ser_q.delete();
        end else begin
            if (fr_act) begin
                fr_age++;
                if (fr_age == 1) begin
                    check("launch_enable", tx_enable, 1);
                    check("launch_grant_id", grant_id, fr_id);
                end else if (fr_age <= 11) begin
                    check("wait_enable_low", tx_enable, 0);
                end
                if (fr_age <= 11) begin
                    check("busy_high", busy, 1);
                    check("tx_data_held", tx_data, fr_data);
                    check("tx_done_timing", tx_done, fr_age == 11);
                    check("no_accept_while_busy", req_ready, 0);
                end else begin
                    check("busy_low_after_frame", busy, 0);
                    check("tx_done_after_frame", tx_done, 0);
                    fr_act = 1'b0;
                end
            end
            if (tx_enable) begin
                check("enable_not_consecutive", prev_en, 0);
                check("enable_while_txm_idle", txm_pos == 0, 1);
            end
            prev_en = tx_enable;
            if (req_ready != '0 && !fr_act) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_accept: got req_ready=%b, required none", req_ready);
                end else begin
                    e = exp_q.pop_front();
                    check("accept_onehot", req_ready, 1 << e.id);
                    if (e.gap != 0) check("accept_gap", cyc - prev_acc, e.gap);
                    ser_q.push_back(e.data);
                    fr_act   = 1'b1;
                    fr_age   = 0;
                    fr_id    = e.id;
                    fr_data  = e.data;
                    prev_acc = cyc;
                end
            end
            if (txm_pos == 1) begin
                check("start_bit", txm_line, 0);
            end else if (txm_pos >= 2 && txm_pos <= 9) begin
                cap[3'(txm_pos - 2)] = txm_line;
            end else if (txm_pos == 10) begin
                check("stop_bit", txm_line, 1);
                if (ser_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL serial_byte: got 0x%0h, required no frame", cap);
                end else begin
                    check("serial_byte", cap, ser_q.pop_front());
                end
            end
        end
    end

    task automatic drive_data();
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = byt[i];
    endtask

    task automatic expect_acc(input int id, input int gap);
        acc_t a;
        a.id   = id;
        a.data = byt[id];
        a.gap  = gap;
        exp_q.push_back(a);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge tx_clk);
        #1;
    endtask

    task automatic wait_accept(input int id);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge tx_clk);
            found = req_ready[id[1:0]];
        end
        check("accept_wait", found, 1);
        @(posedge tx_clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge tx_clk);
        #2 rst_n = 1'b0;
        @(posedge tx_clk);
        #2 rst_n = 1'b1;
        cycles(1);
    endtask

    task automatic run_plan(input logic [NR-1:0] mask);
        foreach (plan[k]) expect_acc(plan[k], (k == 0) ? 0 : 12);
        req_valid = mask;
        foreach (plan[k]) wait_accept(plan[k]);
        req_valid = '0;
        cycles(14);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got sim time %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("reset_tx_data", tx_data, 0);
        check("reset_tx_enable", tx_enable, 0);
        check("reset_req_ready", req_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_grant_id", grant_id, 0);
        check("reset_tx_done", tx_done, 0);
        @(posedge tx_clk);
        #2 rst_n = 1'b1;
        cycles(1);

        // Single request from requester 0.
        byt = '{8'hA5, 8'h00, 8'h00, 8'h00};
        drive_data();
        expect_acc(0, 0);
        req_valid = 4'b0001;
        wait_accept(0);
        req_valid = '0;
        cycles(14);

        // All four continuously valid.
        apply_reset();
        byt = '{8'h10, 8'h21, 8'h32, 8'h43};
        drive_data();
`ifdef UART_ARB_FIXED_PRIO_EN
        plan = '{0, 0, 0, 0, 0};
`else
        plan = '{0, 1, 2, 3, 0};
`endif
        run_plan(4'b1111);

        // Requester 2 arrives during requester 0's WAIT.
        byt[0] = 8'h6E;
        byt[2] = 8'h5C;
        drive_data();
        expect_acc(0, 0);
        req_valid = 4'b0001;
        wait_accept(0);
        req_valid = '0;
        cycles(3);
        expect_acc(2, 12);
        req_valid = 4'b0100;
        wait_accept(2);
        req_valid = '0;
        cycles(14);

        // Requester 1 changes its data after being accepted.
        byt[1] = 8'h3C;
        drive_data();
        expect_acc(1, 0);
        req_valid = 4'b0010;
        wait_accept(1);
        req_valid = '0;
        cycles(3);
        req_data[15:8] = 8'hFF;
        cycles(12);
        check("tx_data_hold_after_frame", tx_data, 8'h3C);
        check("busy_idle_after_frame", busy, 0);

        // Reset in WAIT cycle 5 with requesters 0 and 3 pending.
        byt[2] = 8'h77;
        drive_data();
        expect_acc(2, 0);
        req_valid = 4'b0100;
        wait_accept(2);
        req_valid = '0;
        cycles(5);
        byt[0] = 8'hC3;
        byt[3] = 8'h3F;
        drive_data();
        req_valid = 4'b1001;
        #1 rst_n = 1'b0;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_tx_enable", tx_enable, 0);
        check("midreset_req_ready", req_ready, 0);
        check("midreset_tx_done", tx_done, 0);
        check("midreset_tx_data", tx_data, 0);
        check("midreset_grant_id", grant_id, 0);
        expect_acc(0, 0);
        expect_acc(3, 12);
        @(posedge tx_clk);
        #2 rst_n = 1'b1;
        wait_accept(0);
        req_valid = 4'b1000;
        wait_accept(3);
        req_valid = '0;
        cycles(14);

        // Requesters 0 and 3 continuously valid.
        apply_reset();
        byt[0] = 8'h5A;
        byt[3] = 8'hE7;
        drive_data();
`ifdef UART_ARB_FIXED_PRIO_EN
        plan = '{0, 0, 0, 0};
`else
        plan = '{0, 3, 0, 3};
`endif
        run_plan(4'b1001);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover_expected: got %0d pending accepts, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (8N1, no parity, one bit per tx_clk) between NUM_REQ requesters using round-robin arbitration.
- Accepts one byte per frame through a valid/ready handshake. It latches the byte, issues a single-cycle enable to the transmitter and holds the byte stable for the whole frame.
- Blocks new launches until the transmitter is back in IDLE.
- Sits between the packet/command sources and the transmitter instance; tx_data and tx_enable connect directly to the transmitter's data_in and enable.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, bits per frame; must equal the transmitter's data_width.
- FRAME_CYCLES, DATA_WIDTH+2, transmitter occupancy after its enable is sampled (START + DATA_WIDTH data bits + FINISH).

Ports:
- tx_clk  in  1  single clock, shared with the transmitter.
- rst_n  in  1  asynchronous active-low reset, shared with the transmitter.
- req_valid  in  NUM_REQ  per-requester byte available; held with req_data until accepted.
- req_data  in  NUM_REQ*DATA_WIDTH  packed bytes; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- tx_data  out  DATA_WIDTH  byte to transmitter data_in; registered.
- tx_enable  out  1  one-cycle launch pulse to transmitter enable; registered.
- busy  out  1  high from accept through end of WAIT.
- grant_id  out  $clog2(NUM_REQ)  index of the last accepted requester.
- tx_done  out  1  one-cycle pulse in the last WAIT cycle.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; tx_data=0; tx_enable=0; req_ready=0; busy=0; grant_id=0; tx_done=0; wait counter=0; round-robin pointer last=NUM_REQ-1, so requester 0 wins first.
- States: IDLE, LAUNCH, WAIT.
- IDLE, no req_valid bit set: stay in IDLE; all pulses low.
- IDLE, any req_valid bit set:
  - Winner g = first set bit searching last+1, last+2, ... modulo NUM_REQ.
  - Same cycle: req_ready[g]=1 (combinational from state and req_valid).
  - Next edge: tx_data<=req_data[g]; grant_id<=g; last<=g; busy<=1; state<=LAUNCH.
- LAUNCH (1 cycle): tx_enable=1; tx_data stable; counter loaded with FRAME_CYCLES-1; next state WAIT.
- WAIT (FRAME_CYCLES cycles):
  - Counter decrements each cycle; tx_enable=0; tx_data held.
  - At counter==0: tx_done=1, then next edge goes to IDLE with busy<=0.
- Timing:
  - Accept cycle t: req_ready high.
  - t+1: tx_enable high.
  - t+2..t+1+FRAME_CYCLES: WAIT; transmitter START / data bits / FINISH.
  - t+2+FRAME_CYCLES: IDLE; next accept allowed.
  - Back-to-back frame period = FRAME_CYCLES+2 = 12 cycles at defaults.
- tx_enable must never be high on two consecutive cycles. It must never be high while the transmitter is outside IDLE.
- tx_data must not change from LAUNCH through the end of WAIT, because the transmitter reads data_in live during data bits.
- Requests arriving during LAUNCH/WAIT are not accepted. They stay pending, with no loss, while req_valid is held.
- A requester dropping req_valid before acceptance is simply not served. This is not an error.
- Simultaneous requests: exactly one req_ready bit set per accept. Round-robin guarantees each continuously-valid requester is served within NUM_REQ frames.
- Same requester valid again immediately after its grant: it is served only if no other requester is valid, since the pointer has moved past it.
- Reset mid-frame: outputs return to reset values immediately. The transmitter resets with the same rst_n, so no partial frame resumes.

Optional Feature:
- Macro UART_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; last is unused and held constant.
- Undefined (default): round-robin as above.
- All timing and handshake rules are identical in both modes.

Test Plan:
- Single request: req_valid=4'b0001, req_data[7:0]=8'hA5.
  - req_ready[0] pulses at accept cycle t; tx_enable at t+1 with tx_data=8'hA5; tx_done at t+11; busy low at t+12.
  - Transmitter line shows 0, 1,0,1,0,0,1,0,1, then 1.
- All four valid continuously, bytes 8'h10/8'h21/8'h32/8'h43 for requesters 0..3.
  - Grants in order 0,1,2,3,0 with 12-cycle spacing between req_ready pulses.
  - tx_enable is never high in two consecutive cycles.
- Requester 2 asserts valid during WAIT of requester 0's frame.
  - No req_ready until IDLE; then req_ready[2] is asserted and its byte is transmitted intact.
- Requester 1 changes req_data after acceptance during WAIT.
  - tx_data is unchanged until the next accept; serial output matches the originally accepted byte.
- rst_n pulsed low at cycle 5 of WAIT.
  - busy, tx_enable, req_ready all go 0 immediately; after release, requester 0 wins first.
- With UART_ARB_FIXED_PRIO_EN defined, requesters 0 and 3 continuously valid.
  - Requester 0 is granted every frame; requester 3 is never granted.
